// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freezes
// for a 5-stage in-order core, with saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ins_dec_in,
    input  logic [31:0]      ex_ins,
    input  logic             br_ctrl,
    input  logic             mem_busy,
    output logic             pc_hold,
    output logic             dec_hold,
    output logic             dec_flush,
    output logic             ex_bubble,
    output logic             ex_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    localparam bit         FLUSH_MULTI = (FLUSH_DEPTH > 32'sd1);
    localparam bit         LOAD_MULTI  = (LOAD_LAT > 32'sd1);
    localparam logic [2:0] FLUSH_LOAD  = FLUSH_MULTI ? 3'(FLUSH_DEPTH - 32'sd2) : 3'd0;
    localparam logic [2:0] LOAD_LOAD   = LOAD_MULTI ? 3'(LOAD_LAT - 32'sd2) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b1100111: uses_rs1 = 1'b1;
            default:                            uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default:                            uses_rs2 = 1'b0;
        endcase
    endfunction

    state_t      state_r, state_next_s;
    logic [2:0]  cnt_r, cnt_next_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic        lu_s, flush_acc_s;
    logic [4:0]  ctrl_s;
    logic [4:0]  ex_rd_s;
    logic        unused_bits_s;

    // Bits of the instruction words that hazard detection never looks at.
    assign unused_bits_s = &{1'b0, ins_dec_in[31:25], ins_dec_in[14:7], ex_ins[31:12]};

    assign ex_rd_s = ex_ins[11:7];
    assign lu_s = (ex_ins[6:0] == 7'b0000011) && (ex_rd_s != 5'd0) &&
                  (((ex_rd_s == ins_dec_in[19:15]) && uses_rs1(ins_dec_in[6:0])) ||
                   ((ex_rd_s == ins_dec_in[24:20]) && uses_rs2(ins_dec_in[6:0])));

    // Next-state, down-counter and control decode; ctrl_s = {pc_hold, dec_hold, dec_flush, ex_bubble, ex_hold}.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ctrl_s       = 5'b00000;
        flush_acc_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (br_ctrl) begin
                    ctrl_s       = 5'b00110;
                    flush_acc_s  = 1'b1;
                    state_next_s = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
                    cnt_next_s   = FLUSH_LOAD;
                end else if (mem_busy) begin
                    ctrl_s       = 5'b11001;
                    state_next_s = ST_MEM_WAIT;
                end else if (lu_s) begin
                    ctrl_s       = 5'b11010;
                    state_next_s = LOAD_MULTI ? ST_LOAD_STALL : ST_RUN;
                    cnt_next_s   = LOAD_LOAD;
                end else begin
                    ctrl_s       = 5'b00000;
                end
            end
            ST_LOAD_STALL: begin
                if (mem_busy) begin
                    ctrl_s       = 5'b11001;
                    state_next_s = ST_MEM_WAIT;
                    cnt_next_s   = 3'd0;
                end else if (cnt_r == 3'd0) begin
                    ctrl_s       = 5'b11010;
                    state_next_s = ST_RUN;
                end else begin
                    ctrl_s       = 5'b11010;
                    cnt_next_s   = cnt_r - 3'd1;
                end
            end
            ST_FLUSH: begin
                // A busy memory freezes the flush in place; the remaining count survives.
                if (mem_busy) begin
                    ctrl_s       = 5'b11001;
                end else if (cnt_r == 3'd0) begin
                    ctrl_s       = 5'b00110;
                    state_next_s = ST_RUN;
                end else begin
                    ctrl_s       = 5'b00110;
                    cnt_next_s   = cnt_r - 3'd1;
                end
            end
            ST_MEM_WAIT: begin
                ctrl_s = 5'b11001;
                if (!mem_busy) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_MEM_WAIT;
                end
            end
            default: begin
                state_next_s = ST_RUN;
                cnt_next_s   = 3'd0;
            end
        endcase
    end

    // State and flush/stall down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (ctrl_s[4] && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_acc_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Controls are forced low while reset is held, even with events on the inputs.
    assign pc_hold   = rst & ctrl_s[4];
    assign dec_hold  = rst & ctrl_s[3];
    assign dec_flush = rst & ctrl_s[2];
    assign ex_bubble = rst & ctrl_s[1];
    assign ex_hold   = rst & ctrl_s[0];
    assign state     = state_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two instances (A: FD=2/LL=1/16-bit, B: FD=3/LL=3/4-bit) share stimulus.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP     = 32'h00000033;
    localparam logic [31:0] LW      = 32'h0002A283; // lw x5
    localparam logic [31:0] LW0     = 32'h0002A003; // lw x0
    localparam logic [31:0] ADD     = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] ADD2    = 32'h00508333; // add x6,x1,x5
    localparam logic [31:0] ADDX0   = 32'h00100333; // add x6,x0,x1
    localparam logic [31:0] LUI     = 32'h000282B7; // lui x5 (rs1 field = 5)
    localparam logic [31:0] ADDI_NO = 32'h00508313; // addi x6,x1,5
    localparam logic [31:0] ADDI_Y  = 32'h00128313; // addi x6,x5,1
    localparam logic [4:0] C0  = 5'b00000;
    localparam logic [4:0] STL = 5'b11010;
    localparam logic [4:0] FLS = 5'b00110;
    localparam logic [4:0] MW  = 5'b11001;

    typedef struct {
        logic        br;
        logic        mem;
        logic [31:0] ex;
        logic [31:0] dec;
        logic [4:0]  ca;
        logic [1:0]  sa;
        logic [4:0]  cb;
        logic [1:0]  sb;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] ins_dec_in, ex_ins;
    logic br_ctrl, mem_busy;
    logic a_pc, a_dh, a_df, a_eb, a_eh, b_pc, b_dh, b_df, b_eb, b_eh;
    logic [1:0] a_st, b_st;
    logic [15:0] a_stall, a_flush;
    logic [3:0] b_stall, b_flush;

    int n_checks = 0;
    int n_fail = 0;
    vec_t vecs[27];
    vec_t sb_q[$];
    vec_t e;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .ins_dec_in(ins_dec_in), .ex_ins(ex_ins),
        .br_ctrl(br_ctrl), .mem_busy(mem_busy),
        .pc_hold(a_pc), .dec_hold(a_dh), .dec_flush(a_df), .ex_bubble(a_eb), .ex_hold(a_eh),
        .state(a_st), .stall_cnt(a_stall), .flush_cnt(a_flush));

    pipe_hazard_ctrl #(.FLUSH_DEPTH(3), .LOAD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ins_dec_in(ins_dec_in), .ex_ins(ex_ins),
        .br_ctrl(br_ctrl), .mem_busy(mem_busy),
        .pc_hold(b_pc), .dec_hold(b_dh), .dec_flush(b_df), .ex_bubble(b_eb), .ex_hold(b_eh),
        .state(b_st), .stall_cnt(b_stall), .flush_cnt(b_flush));

    function automatic vec_t mk(input logic br, input logic mem, input logic [31:0] ex,
                                input logic [31:0] dec, input logic [4:0] ca, input logic [1:0] sa,
                                input logic [4:0] cb, input logic [1:0] sb);
        vec_t v;
        v.br = br; v.mem = mem; v.ex = ex; v.dec = dec;
        v.ca = ca; v.sa = sa; v.cb = cb; v.sb = sb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic br, input logic mem, input logic [31:0] ex, input logic [31:0] dec);
        br_ctrl = br; mem_busy = mem; ex_ins = ex; ins_dec_in = dec;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, NOP);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, C0,  2'd0);
        vecs[1]  = mk(1'b0, 1'b0, LW,  ADD,     STL, 2'd0, STL, 2'd0);
        vecs[2]  = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, STL, 2'd1);
        vecs[3]  = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, STL, 2'd1);
        vecs[4]  = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, C0,  2'd0);
        vecs[5]  = mk(1'b0, 1'b0, LW,  ADD2,    STL, 2'd0, STL, 2'd0);
        vecs[6]  = mk(1'b0, 1'b1, NOP, NOP,     MW,  2'd0, MW,  2'd1);
        vecs[7]  = mk(1'b1, 1'b0, NOP, NOP,     MW,  2'd3, MW,  2'd3);
        vecs[8]  = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, C0,  2'd0);
        vecs[9]  = mk(1'b0, 1'b0, LW,  LUI,     C0,  2'd0, C0,  2'd0);
        vecs[10] = mk(1'b0, 1'b0, LW,  ADDI_NO, C0,  2'd0, C0,  2'd0);
        vecs[11] = mk(1'b0, 1'b0, LW0, ADDX0,   C0,  2'd0, C0,  2'd0);
        vecs[12] = mk(1'b1, 1'b0, NOP, NOP,     FLS, 2'd0, FLS, 2'd0);
        vecs[13] = mk(1'b1, 1'b0, LW,  ADD,     FLS, 2'd2, FLS, 2'd2);
        vecs[14] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, FLS, 2'd2);
        vecs[15] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, C0,  2'd0);
        vecs[16] = mk(1'b1, 1'b1, LW,  ADD,     FLS, 2'd0, FLS, 2'd0);
        vecs[17] = mk(1'b0, 1'b1, NOP, NOP,     MW,  2'd2, MW,  2'd2);
        vecs[18] = mk(1'b0, 1'b1, NOP, NOP,     MW,  2'd2, MW,  2'd2);
        vecs[19] = mk(1'b0, 1'b0, NOP, NOP,     FLS, 2'd2, FLS, 2'd2);
        vecs[20] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, FLS, 2'd2);
        vecs[21] = mk(1'b0, 1'b1, LW,  ADD,     MW,  2'd0, MW,  2'd0);
        vecs[22] = mk(1'b0, 1'b0, LW,  ADD,     MW,  2'd3, MW,  2'd3);
        vecs[23] = mk(1'b0, 1'b0, LW,  ADDI_Y,  STL, 2'd0, STL, 2'd0);
        vecs[24] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, STL, 2'd1);
        vecs[25] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, STL, 2'd1);
        vecs[26] = mk(1'b0, 1'b0, NOP, NOP,     C0,  2'd0, C0,  2'd0);

        // Reset held with every event asserted: controls must stay low.
        rst = 1'b0;
        drive(1'b1, 1'b1, LW, ADD);
        #12;
        check("rst_ctrl_a", {a_pc, a_dh, a_df, a_eb, a_eh}, C0);
        check("rst_ctrl_b", {b_pc, b_dh, b_df, b_eb, b_eh}, C0);
        check("rst_state", {a_st, b_st}, 4'h0);
        check("rst_cnts", {a_stall, a_flush, b_stall, b_flush}, 40'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, NOP);
        rst = 1'b1;

        // Table vectors through the scoreboard queue.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(vecs[i].br, vecs[i].mem, vecs[i].ex, vecs[i].dec);
            sb_q.push_back(vecs[i]);
            #2;
            e = sb_q.pop_front();
            check($sformatf("vec%0d_ctrl_a", i), {a_pc, a_dh, a_df, a_eb, a_eh}, e.ca);
            check($sformatf("vec%0d_state_a", i), a_st, e.sa);
            check($sformatf("vec%0d_ctrl_b", i), {b_pc, b_dh, b_df, b_eb, b_eh}, e.cb);
            check($sformatf("vec%0d_state_b", i), b_st, e.sb);
        end
        @(negedge clk);
        #2;
        check("tbl_stall_a", a_stall, 16'd9);
        check("tbl_flush_a", a_flush, 16'd2);
        check("tbl_stall_b", b_stall, 4'd13);
        check("tbl_flush_b", b_flush, 4'd2);

        // Asynchronous reset in the middle of a load stall on B.
        @(negedge clk);
        drive(1'b0, 1'b0, LW, ADD);
        #2;
        check("pre_rst_ctrl_b", {b_pc, b_dh, b_df, b_eb, b_eh}, STL);
        @(posedge clk);
        #2;
        check("mid_stall_state_b", b_st, 2'd1);
        rst = 1'b0;
        br_ctrl = 1'b1;
        #1;
        check("async_rst_ctrl_b", {b_pc, b_dh, b_df, b_eb, b_eh}, C0);
        check("async_rst_ctrl_a", {a_pc, a_dh, a_df, a_eb, a_eh}, C0);
        check("async_rst_state_b", b_st, 2'd0);
        check("async_rst_cnt_b", {b_stall, b_flush}, 8'h00);
        check("async_rst_cnt_a", {a_stall, a_flush}, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, NOP);
        #2;
        rst = 1'b1;
        #1;
        check("rel_ctrl_b", {b_pc, b_dh, b_df, b_eb, b_eh}, C0);
        @(negedge clk);
        #2;
        check("no_residual_b", {b_pc, b_dh, b_df, b_eb, b_eh, b_st}, 7'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, NOP, NOP);
        #2;
        check("post_rst_br_a", {a_pc, a_dh, a_df, a_eb, a_eh}, FLS);
        @(negedge clk);
        drive(1'b0, 1'b0, NOP, NOP);
        #2;
        check("post_rst_flush_st", {a_st, b_st}, 4'b1010);
        check("post_rst_flush_cnt", a_flush, 16'd1);

        // Flush counter saturation on the 4-bit instance.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, NOP, NOP);
            repeat (2) begin
                @(negedge clk);
                drive(1'b0, 1'b0, NOP, NOP);
            end
        end
        @(negedge clk);
        #2;
        check("flush_sat_b", b_flush, 4'hF);
        check("flush_cnt_a", a_flush, 16'd20);

        // Stall counter saturation: 2^16+5 cycles of mem_busy.
        do_reset();
        @(negedge clk);
        drive(1'b0, 1'b1, NOP, NOP);
        repeat (65541) @(negedge clk);
        drive(1'b0, 1'b0, NOP, NOP);
        #2;
        check("stall_sat_a", a_stall, 16'hFFFF);
        check("stall_sat_b", b_stall, 4'hF);
        check("sat_state_a", a_st, 2'd3);
        @(negedge clk);
        #2;
        check("sat_hold_a", a_stall, 16'hFFFF);
        check("sat_run_a", a_st, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2: total cycles decode/execute are squashed after a taken branch (legal 1..7).
REQ-002 Parameter LOAD_LAT, default 1: total stall cycles inserted per load-use hazard (legal 1..7).
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 ins_dec_in  in  32  instruction currently in the read/decode stage.
REQ-007 ex_ins  in  32  instruction currently in the execute stage.
REQ-008 br_ctrl  in  1  taken branch/jump resolved in execute this cycle.
REQ-009 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-010 pc_hold  out  1  PC register keeps its value.
REQ-011 dec_hold  out  1  decode-stage register keeps its value.
REQ-012 dec_flush  out  1  decode-stage register loads NOP (32'h00000033).
REQ-013 ex_bubble  out  1  execute stage loads NOP instead of the decode instruction.
REQ-014 ex_hold  out  1  execute-stage and later registers keep their values.
REQ-015 state  out  2  FSM state: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with pc_hold=1.
REQ-017 flush_cnt  out  CNT_W  saturating count of taken-branch events accepted.

Function
REQ-018 Load-use hazard (lu) SHALL be: ex_ins[6:0]==7'b0000011, ex_rd=ex_ins[11:7]!=0, and (ex_rd==ins_dec_in[19:15] with rs1 used) or (ex_rd==ins_dec_in[24:20] with rs2 used).
REQ-019 rs1 SHALL be used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111; rs2 for 0110011, 0100011, 1100011 only; all other opcodes use neither.
REQ-020 In RUN, event priority per cycle SHALL be br_ctrl > mem_busy > lu.
REQ-021 RUN, br_ctrl=1: dec_flush=1, ex_bubble=1 same cycle (combinational); next state FLUSH if FLUSH_DEPTH>1, else RUN; flush_cnt increments.
REQ-022 RUN, mem_busy=1 (no br_ctrl): pc_hold=dec_hold=ex_hold=1, ex_bubble=0 same cycle; next state MEM_WAIT.
REQ-023 RUN, lu=1 (no br_ctrl, no mem_busy): pc_hold=dec_hold=ex_bubble=1, ex_hold=0 same cycle; next state LOAD_STALL if LOAD_LAT>1, else RUN.
REQ-024 RUN with no event: all control outputs 0.
REQ-025 A 3-bit down-counter SHALL load FLUSH_DEPTH-2 or LOAD_LAT-2 on entry to FLUSH/LOAD_STALL; the state returns to RUN on the edge where the counter is 0, decrementing otherwise.
REQ-026 LOAD_STALL outputs: pc_hold=dec_hold=ex_bubble=1, ex_hold=0; br_ctrl and lu ignored; mem_busy=1 SHALL override to MEM_WAIT outputs and transition, discarding the remaining count.
REQ-027 FLUSH outputs: dec_flush=ex_bubble=1, pc_hold=dec_hold=ex_hold=0; br_ctrl and lu ignored; mem_busy=1 SHALL freeze (MEM_WAIT outputs) without decrementing and without leaving FLUSH.
REQ-028 MEM_WAIT outputs: pc_hold=dec_hold=ex_hold=1, others 0; return to RUN on the first edge with mem_busy=0; br_ctrl, lu ignored while in MEM_WAIT.
REQ-029 dec_flush and dec_hold SHALL never both be 1; ex_bubble and ex_hold SHALL never both be 1.
REQ-030 stall_cnt increments on every edge where pc_hold=1; both counters saturate at all-ones.

Reset
REQ-031 rst=0 SHALL immediately force state=RUN, internal counter=0, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-032 While rst=0 all control outputs SHALL be 0; an assertion mid-stall or mid-flush aborts it with no residual holds after release.
REQ-033 After rst deassertion the first posedge SHALL evaluate RUN rules normally.

Verification
REQ-034 ex_ins=32'h0002A283 (lw x5), ins_dec_in=32'h00128333 (add x6,x5,x1), LOAD_LAT=1 -> one cycle pc_hold=dec_hold=ex_bubble=1, state stays 0, stall_cnt=1.
REQ-035 Same stimulus, LOAD_LAT=3 -> holds for 3 consecutive cycles, state=1 for cycles 2-3, then 0; stall_cnt=3.
REQ-036 br_ctrl=1 one cycle, FLUSH_DEPTH=2 -> dec_flush=ex_bubble=1 for 2 cycles, state 0->2->0, flush_cnt=1.
REQ-037 br_ctrl=1 and mem_busy=1 and lu=1 same cycle -> flush wins; mem_busy held 2 more cycles -> FLUSH frozen with holds, then completes remaining flush cycle.
REQ-038 lw x0 in execute with dec using x0 -> no stall; rst pulsed low during LOAD_STALL -> all outputs 0 asynchronously, counters 0.
REQ-039 Drive 2^CNT_W+5 stall cycles via mem_busy=1 -> stall_cnt holds at all-ones.
